// File: rtl/sr_pkg.sv
// Shared types and constants for the SR flip-flop excitation driver.
// Holds the FSM encoding, the active-low drive levels and the excitation table.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic ASSERT_N   = 1'b0;
  localparam logic DEASSERT_N = 1'b1;

  typedef struct packed {
    logic s_n;
    logic r_n;
  } sr_drive_t;

  // Excitation table: pulse only the input that moves Q toward the target.
  function automatic sr_drive_t excite(input logic tgt, input logic q);
    sr_drive_t d;
    d.s_n = DEASSERT_N;
    d.r_n = DEASSERT_N;
    if (tgt && !q)      d.s_n = ASSERT_N;
    else if (!tgt && q) d.r_n = ASSERT_N;
    return d;
  endfunction

endpackage

// File: rtl/sr_req_fifo.sv
// DEPTH-entry, 1-bit-wide synchronous request FIFO with show-ahead output.
// Push is ignored when full and pop is ignored when empty.
module sr_req_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the count and pointers
  // alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/sr_excitation_driver.sv
// Drives the active-low S_N/R_N of a downstream SR flip-flop so its Q follows
// a stream of buffered target bits, and counts results that fail to land.
module sr_excitation_driver
  import sr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_d,
  output logic             s_n,
  output logic             r_n,
  input  logic             q_fb,
  input  logic             clr_err,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t    state;
  logic      tgt;
  logic      fifo_dout;
  logic      fifo_full;
  logic      fifo_empty;
  logic      pop;
  logic      mismatch;
  sr_drive_t drv;

  sr_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid && req_ready),
    .pop   (pop),
    .din   (req_d),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign req_ready = !fifo_full;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign drv       = excite(fifo_dout, q_fb);
  assign mismatch  = (q_fb != tgt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tgt     <= 1'b0;
      s_n     <= DEASSERT_N;
      r_n     <= DEASSERT_N;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            tgt   <= fifo_dout;
            s_n   <= drv.s_n;
            r_n   <= drv.r_n;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          s_n   <= DEASSERT_N;
          r_n   <= DEASSERT_N;
          state <= CHECK;
        end
        CHECK:   state <= IDLE;
        default: state <= IDLE;
      endcase

      // A mismatch wins over a coincident clear, leaving a fresh count of one.
      if (state == CHECK && mismatch) begin
        err <= 1'b1;
        if (clr_err)                 err_cnt <= CNT_ONE;
        else if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
      end else if (clr_err) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end
    end
  end

endmodule
